// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: condition codes, FSM encoding
// and the status-flag bundle also used by the ALU flag register.
package branch_resolver_pkg;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_HS = 4'd2;
    localparam logic [3:0] COND_LO = 4'd3;
    localparam logic [3:0] COND_HI = 4'd4;
    localparam logic [3:0] COND_LS = 4'd5;
    localparam logic [3:0] COND_LT = 4'd6;
    localparam logic [3:0] COND_GE = 4'd7;
    localparam logic [3:0] COND_GT = 4'd8;
    localparam logic [3:0] COND_LE = 4'd9;
    localparam logic [3:0] COND_UC = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLAGWAIT = 2'd1,
        ST_RESP     = 2'd2
    } br_state_t;

    typedef struct packed {
        logic low;
        logic negative;
        logic zero;
    } flags_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition-code evaluator: decides taken/illegal from the
// condition code and the {low, negative, zero} flag bundle.
module branch_cond_eval
    import branch_resolver_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [2:0] flags,
    output logic       taken,
    output logic       illegal
);

    flags_t f_s;
    assign f_s = flags_t'(flags);

    // Condition table; codes 10-13 are reserved and never taken
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (cond)
            COND_EQ: taken = f_s.zero;
            COND_NE: taken = !f_s.zero;
            COND_HS: taken = !f_s.low;
            COND_LO: taken = f_s.low;
            COND_HI: taken = !f_s.low && !f_s.zero;
            COND_LS: taken = f_s.low || f_s.zero;
            COND_LT: taken = f_s.negative;
            COND_GE: taken = !f_s.negative;
            COND_GT: taken = !f_s.negative && !f_s.zero;
            COND_LE: taken = f_s.negative || f_s.zero;
            COND_UC: taken = 1'b1;
            COND_NV: taken = 1'b0;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Conditional-branch resolver: waits out flag writes, evaluates the condition
// and hands next PC to fetch. Define BRANCH_STATS_EN for taken/not-taken counters.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DISP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  br_valid,
    output logic                  br_ready,
    input  logic [3:0]            br_cond,
    input  logic [ADDR_WIDTH-1:0] br_pc,
    input  logic [DISP_WIDTH-1:0] br_disp,
    input  logic                  low,
    input  logic                  negative,
    input  logic                  zero,
    input  logic                  flag_wr_pending,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_taken,
    output logic [ADDR_WIDTH-1:0] res_target,
    output logic                  res_illegal
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]           stat_taken,
    output logic [15:0]           stat_not_taken
`endif
);

    br_state_t             state_r;
    logic [3:0]            cond_r;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic [DISP_WIDTH-1:0] disp_r;

    logic [3:0]            cond_s;
    logic [ADDR_WIDTH-1:0] pc_s;
    logic [DISP_WIDTH-1:0] disp_s;
    logic [ADDR_WIDTH-1:0] fall_s;
    logic [ADDR_WIDTH-1:0] jump_s;
    logic [ADDR_WIDTH-1:0] target_s;
    logic                  taken_s;
    logic                  illegal_s;

    // In IDLE the request is evaluated straight from the bus; later, from the latched copy
    always_comb begin
        if (state_r == ST_IDLE) begin
            cond_s = br_cond;
            pc_s   = br_pc;
            disp_s = br_disp;
        end else begin
            cond_s = cond_r;
            pc_s   = pc_r;
            disp_s = disp_r;
        end
    end

    branch_cond_eval u_eval (
        .cond    (cond_s),
        .flags   ({low, negative, zero}),
        .taken   (taken_s),
        .illegal (illegal_s)
    );

    assign fall_s   = pc_s + ADDR_WIDTH'(1'b1);
    assign jump_s   = fall_s + ADDR_WIDTH'($signed(disp_s));
    assign target_s = taken_s ? jump_s : fall_s;

    // Request FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            br_ready    <= 1'b1;
            res_valid   <= 1'b0;
            res_taken   <= 1'b0;
            res_target  <= {ADDR_WIDTH{1'b0}};
            res_illegal <= 1'b0;
            cond_r      <= 4'd0;
            pc_r        <= {ADDR_WIDTH{1'b0}};
            disp_r      <= {DISP_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (br_valid && br_ready) begin
                        cond_r   <= br_cond;
                        pc_r     <= br_pc;
                        disp_r   <= br_disp;
                        br_ready <= 1'b0;
                        if (flag_wr_pending) begin
                            state_r <= ST_FLAGWAIT;
                        end else begin
                            res_taken   <= taken_s;
                            res_target  <= target_s;
                            res_illegal <= illegal_s;
                            res_valid   <= 1'b1;
                            state_r     <= ST_RESP;
                        end
                    end
                end
                ST_FLAGWAIT: begin
                    if (!flag_wr_pending) begin
                        res_taken   <= taken_s;
                        res_target  <= target_s;
                        res_illegal <= illegal_s;
                        res_valid   <= 1'b1;
                        state_r     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        br_ready  <= 1'b1;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    br_ready  <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating outcome counters, bumped once per accepted result
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_taken     <= 16'd0;
            stat_not_taken <= 16'd0;
        end else if (res_valid && res_ready) begin
            if (res_taken) begin
                if (stat_taken != 16'hFFFF) begin
                    stat_taken <= stat_taken + 16'd1;
                end
            end else begin
                if (stat_not_taken != 16'hFFFF) begin
                    stat_not_taken <= stat_not_taken + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver (stats checks need BRANCH_STATS_EN).
module tb_branch_resolver;
    import branch_resolver_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        br_valid = 1'b0;
    logic        br_ready;
    logic [3:0]  br_cond = 4'd0;
    logic [15:0] br_pc = 16'd0;
    logic [7:0]  br_disp = 8'd0;
    logic        low = 1'b0, negative = 1'b0, zero = 1'b0;
    logic        flag_wr_pending = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic        res_taken;
    logic [15:0] res_target;
    logic        res_illegal;
`ifdef BRANCH_STATS_EN
    logic [15:0] stat_taken, stat_not_taken;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Hand-computed taken masks, bit index = {L,N,Z}
    logic [7:0] mask_tbl [0:15] = '{8'hAA, 8'h55, 8'h0F, 8'hF0, 8'h05, 8'hFA, 8'hCC, 8'h33,
                                    8'h11, 8'hEE, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};

    branch_resolver dut (
        .clk             (clk),
        .reset           (reset),
        .br_valid        (br_valid),
        .br_ready        (br_ready),
        .br_cond         (br_cond),
        .br_pc           (br_pc),
        .br_disp         (br_disp),
        .low             (low),
        .negative        (negative),
        .zero            (zero),
        .flag_wr_pending (flag_wr_pending),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_taken       (res_taken),
        .res_target      (res_target),
        .res_illegal     (res_illegal)
`ifdef BRANCH_STATS_EN
        ,
        .stat_taken      (stat_taken),
        .stat_not_taken  (stat_not_taken)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one branch; pend = cycles flag_wr_pending is high starting at the accept cycle
    task automatic do_branch(input string tag, input logic [3:0] c, input logic [15:0] pc,
                             input logic [7:0] d, input logic [2:0] fb, input logic [2:0] fa,
                             input int pend, input logic et, input logic [15:0] etgt,
                             input logic eill);
        int lat;
        lat = 0;
        br_valid = 1'b1; br_cond = c; br_pc = pc; br_disp = d;
        {low, negative, zero} = fb;
        flag_wr_pending = (pend > 0);
        res_ready = 1'b1;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                br_valid = 1'b0; br_cond = ~c; br_pc = ~pc; br_disp = ~d;
                if (pend > 0) {low, negative, zero} = fa;
            end
            flag_wr_pending = (lat < pend);
        end while (!res_valid && lat < 20);
        check({tag, "_valid"}, res_valid, 1'b1);
        check({tag, "_lat"}, lat, (pend == 0) ? 1 : pend + 1);
        check({tag, "_taken"}, res_taken, et);
        check({tag, "_target"}, res_target, etgt);
        check({tag, "_illegal"}, res_illegal, eill);
        @(posedge clk); #1;
        check({tag, "_done"}, {res_valid, br_ready}, 2'b01);
    endtask

    initial begin
        logic et;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_ready", br_ready, 1'b1);
        check("rst_outs", {res_valid, res_taken, res_illegal, res_target}, 19'd0);
        @(posedge clk); #1;
        check("idle_no_req", res_valid, 1'b0);

        do_branch("eq_basic", COND_EQ, 16'h0010, 8'h05, 3'b001, 3'b001, 0, 1'b1, 16'h0016, 1'b0);
        do_branch("eq_hazard", COND_EQ, 16'h0010, 8'h05, 3'b001, 3'b000, 2, 1'b0, 16'h0011, 1'b0);
        do_branch("wrap_pos", COND_UC, 16'hFFFE, 8'h7F, 3'b000, 3'b000, 0, 1'b1, 16'h007E, 1'b0);
        do_branch("wrap_neg", COND_UC, 16'h0005, 8'h80, 3'b000, 3'b000, 0, 1'b1, 16'hFF86, 1'b0);
        do_branch("wrap_fall", COND_NV, 16'hFFFF, 8'h10, 3'b000, 3'b000, 0, 1'b0, 16'h0000, 1'b0);

        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 8; f++) begin
                et = mask_tbl[c][f];
                do_branch($sformatf("c%0d_f%0d", c, f), 4'(c), 16'h0100, 8'h03, 3'(f), 3'(f), 0,
                          et, et ? 16'h0104 : 16'h0101, (c >= 10 && c <= 13));
            end
        end

        // Result stall, then reset while holding a result
        br_valid = 1'b1; br_cond = COND_EQ; br_pc = 16'h0020; br_disp = 8'h02;
        {low, negative, zero} = 3'b001; flag_wr_pending = 1'b0; res_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            br_valid = 1'b1; br_cond = COND_NV; br_pc = 16'hAAAA; zero = 1'b0;
            check($sformatf("stall%0d", i),
                  {res_valid, br_ready, res_taken, res_illegal, res_target}, {4'b1010, 16'h0023});
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; br_valid = 1'b0;
        check("stall_rst", {res_valid, br_ready, res_target}, {2'b01, 16'h0000});
        @(posedge clk); #1;
        check("stall_rst_nopulse", {res_valid, br_ready}, 2'b01);

`ifdef BRANCH_STATS_EN
        check("stat_rst", {stat_taken, stat_not_taken}, 32'd0);
        for (int i = 0; i < 3; i++)
            do_branch("st_t", COND_UC, 16'h0000, 8'h01, 3'b000, 3'b000, 0, 1'b1, 16'h0002, 1'b0);
        do_branch("st_n", COND_NV, 16'h0000, 8'h01, 3'b000, 3'b000, 0, 1'b0, 16'h0001, 1'b0);
        do_branch("st_i", 4'd10, 16'h0000, 8'h01, 3'b000, 3'b000, 0, 1'b0, 16'h0001, 1'b1);
        check("stat_taken3", stat_taken, 16'd3);
        check("stat_not2", stat_not_taken, 16'd2);
        force dut.stat_taken = 16'hFFFF;
        #1 release dut.stat_taken;
        do_branch("st_sat", COND_UC, 16'h0000, 8'h01, 3'b000, 3'b000, 0, 1'b1, 16'h0002, 1'b0);
        check("stat_sat", stat_taken, 16'hFFFF);
        check("stat_not_keep", stat_not_taken, 16'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
